// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Client memory stage: inferred BRAM blocks plus SB_SPRAM256KA sequencing FSM.
// Optional: define MEM_CTRL_WR_FORWARD_EN for write-first BRAM same-address read/write.
module mem_access_ctrl #(
  parameter int MEM_SELECT_BITS = 4,
  parameter int NUM_BLOCKS      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MEM_SELECT_BITS-1:0] mem_select,
  input  logic [7:0]                 rd_addr,
  input  logic [7:0]                 wr_addr,
  input  logic [15:0]                data_in,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic                       bram_or_spram,
  output logic [15:0]                mem_data_out,
  output logic                       rd_valid,
  output logic                       busy,
  output logic [13:0]                spram_addr,
  output logic [15:0]                spram_wdata,
  output logic                       spram_cs,
  output logic                       spram_wren,
  input  logic [15:0]                spram_rdata
);

  typedef enum logic [1:0] {IDLE, SP_RD, SP_CAP, SP_WR} state_t;

  localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [MEM_SELECT_BITS:0] NB_LIM = (MEM_SELECT_BITS + 1)'(NUM_BLOCKS);

  state_t      state;
  logic [15:0] bram [NUM_BLOCKS][256];

  logic [BLK_W-1:0] blk;
  logic             sel_ok;
  logic [5:0]       sel6;
  logic [15:0]      bram_rd;
  logic             fwd;

  logic [5:0]  lat_sel6;
  logic [7:0]  lat_wr_addr;
  logic [15:0] lat_data;
  logic        lat_wr;

  assign busy    = (state != IDLE);
  assign blk     = mem_select[BLK_W-1:0];
  assign sel_ok  = ({1'b0, mem_select} < NB_LIM);
  assign bram_rd = bram[blk][rd_addr];

  // SPRAM address holds 6 select bits; wider selects are truncated.
  if (MEM_SELECT_BITS >= 6) begin : g_sel_trunc
    assign sel6 = mem_select[5:0];
  end else begin : g_sel_ext
    assign sel6 = {{(6 - MEM_SELECT_BITS){1'b0}}, mem_select};
  end

`ifdef MEM_CTRL_WR_FORWARD_EN
  assign fwd = wr_en && (wr_addr == rd_addr);
`else
  assign fwd = 1'b0;
`endif

  // Contents are intentionally never reset so the arrays map onto EBR.
  always_ff @(posedge clk) begin
    if (state == IDLE && !bram_or_spram && wr_en && sel_ok)
      bram[blk][wr_addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_data_out <= 16'h0000;
      rd_valid     <= 1'b0;
      spram_addr   <= 14'h0000;
      spram_wdata  <= 16'h0000;
      spram_cs     <= 1'b0;
      spram_wren   <= 1'b0;
      lat_sel6     <= 6'h00;
      lat_wr_addr  <= 8'h00;
      lat_data     <= 16'h0000;
      lat_wr       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!bram_or_spram) begin
            if (rd_en) begin
              rd_valid     <= 1'b1;
              mem_data_out <= !sel_ok ? 16'h0000 : (fwd ? data_in : bram_rd);
            end
          end else begin
            lat_sel6    <= sel6;
            lat_wr_addr <= wr_addr;
            lat_data    <= data_in;
            lat_wr      <= wr_en;
            if (rd_en) begin
              state      <= SP_RD;
              spram_cs   <= 1'b1;
              spram_wren <= 1'b0;
              spram_addr <= {sel6, rd_addr};
            end else if (wr_en) begin
              state       <= SP_WR;
              spram_cs    <= 1'b1;
              spram_wren  <= 1'b1;
              spram_addr  <= {sel6, wr_addr};
              spram_wdata <= data_in;
            end
          end
        end
        SP_RD: begin
          state    <= SP_CAP;
          spram_cs <= 1'b0;
        end
        SP_CAP: begin
          mem_data_out <= spram_rdata;
          rd_valid     <= 1'b1;
          // Read is always serviced before the latched write, giving old-data semantics.
          if (lat_wr) begin
            state       <= SP_WR;
            spram_cs    <= 1'b1;
            spram_wren  <= 1'b1;
            spram_addr  <= {lat_sel6, lat_wr_addr};
            spram_wdata <= lat_data;
          end else begin
            state <= IDLE;
          end
        end
        SP_WR: begin
          state      <= IDLE;
          spram_cs   <= 1'b0;
          spram_wren <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Directed self-checking bench for mem_access_ctrl (NUM_BLOCKS=8).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mem_select = '0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        bram_or_spram = 1'b0;
  logic [15:0] mem_data_out;
  logic        rd_valid;
  logic        busy;
  logic [13:0] spram_addr;
  logic [15:0] spram_wdata;
  logic        spram_cs;
  logic        spram_wren;
  logic [15:0] spram_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_same;

  mem_access_ctrl #(.MEM_SELECT_BITS(4), .NUM_BLOCKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_select(mem_select), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en), .wr_en(wr_en),
    .bram_or_spram(bram_or_spram), .mem_data_out(mem_data_out),
    .rd_valid(rd_valid), .busy(busy), .spram_addr(spram_addr),
    .spram_wdata(spram_wdata), .spram_cs(spram_cs), .spram_wren(spram_wren),
    .spram_rdata(spram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic sp, input logic [3:0] sel, input logic re, input logic [7:0] ra,
                     input logic we, input logic [7:0] wa, input logic [15:0] d);
    bram_or_spram = sp; mem_select = sel; rd_en = re; rd_addr = ra;
    wr_en = we; wr_addr = wa; data_in = d;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_data", mem_data_out, 16'h0000);
    chk("rst_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_cs", {15'd0, spram_cs}, 16'd0);
    chk("rst_wren", {15'd0, spram_wren}, 16'd0);
    chk("rst_addr", {2'b0, spram_addr}, 16'h0000);
    chk("rst_wdata", spram_wdata, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // BRAM write then read, one-cycle latency, single-cycle valid
    req(0, 4'd0, 0, 8'd0, 1, 8'd1, 16'h0010);
    tick();
    chk("bw_novalid", {15'd0, rd_valid}, 16'd0);
    req(0, 4'd0, 1, 8'd1, 0, 8'd0, 16'h0000);
    tick();
    chk("br_data", mem_data_out, 16'h0010);
    chk("br_valid", {15'd0, rd_valid}, 16'd1);
    idle();
    tick();
    chk("br_pulse", {15'd0, rd_valid}, 16'd0);
    chk("br_hold", mem_data_out, 16'h0010);

    // Same-cycle read+write on bram[3][7]
    req(0, 4'd3, 0, 8'd0, 1, 8'd7, 16'h1111);
    tick();
    req(0, 4'd3, 1, 8'd7, 1, 8'd7, 16'h2222);
    tick();
`ifdef MEM_CTRL_WR_FORWARD_EN
    exp_same = 16'h2222;
`else
    exp_same = 16'h1111;
`endif
    chk("rw_same", mem_data_out, exp_same);
    req(0, 4'd3, 1, 8'd7, 0, 8'd0, 16'h0000);
    tick();
    chk("rw_after", mem_data_out, 16'h2222);

    // Adder-style feedback loop
    req(0, 4'd0, 0, 8'd0, 1, 8'd1, 16'h0003);
    tick();
    for (int i = 0; i < 3; i++) begin
      req(0, 4'd0, 1, 8'd1, 1, 8'd2, mem_data_out + 16'd5);
      tick();
    end
    req(0, 4'd0, 1, 8'd2, 0, 8'd0, 16'h0000);
    tick();
    chk("adder", mem_data_out, 16'h0008);

    // SPRAM read+write
    req(1, 4'd2, 1, 8'h05, 1, 8'h06, 16'hCAFE);
    tick();
    chk("sp_rd_busy", {15'd0, busy}, 16'd1);
    chk("sp_rd_cs", {15'd0, spram_cs}, 16'd1);
    chk("sp_rd_wren", {15'd0, spram_wren}, 16'd0);
    chk("sp_rd_addr", {2'b0, spram_addr}, 16'h0205);
    req(1, 4'd9, 1, 8'h33, 1, 8'h44, 16'h7777);
    spram_rdata = 16'hBEEF;
    tick();
    chk("sp_cap_busy", {15'd0, busy}, 16'd1);
    chk("sp_cap_cs", {15'd0, spram_cs}, 16'd0);
    chk("sp_cap_valid", {15'd0, rd_valid}, 16'd0);
    tick();
    chk("sp_wr_busy", {15'd0, busy}, 16'd1);
    chk("sp_wr_cs", {15'd0, spram_cs}, 16'd1);
    chk("sp_wr_wren", {15'd0, spram_wren}, 16'd1);
    chk("sp_wr_addr", {2'b0, spram_addr}, 16'h0206);
    chk("sp_wr_wdata", spram_wdata, 16'hCAFE);
    chk("sp_rd_data", mem_data_out, 16'hBEEF);
    chk("sp_rd_valid", {15'd0, rd_valid}, 16'd1);
    idle();
    tick();
    chk("sp_done_busy", {15'd0, busy}, 16'd0);
    chk("sp_done_wren", {15'd0, spram_wren}, 16'd0);
    chk("sp_done_valid", {15'd0, rd_valid}, 16'd0);
    chk("sp_ignored", {2'b0, spram_addr}, 16'h0206);

    // SPRAM write-only
    req(1, 4'd0, 0, 8'h00, 1, 8'h80, 16'h1234);
    tick();
    idle();
    chk("spw_busy", {15'd0, busy}, 16'd1);
    chk("spw_addr", {2'b0, spram_addr}, 16'h0080);
    chk("spw_wdata", spram_wdata, 16'h1234);
    chk("spw_wren", {15'd0, spram_wren}, 16'd1);
    tick();
    chk("spw_done", {15'd0, busy}, 16'd0);
    chk("spw_novalid", {15'd0, rd_valid}, 16'd0);

    // Reset during SP_CAP of read+write
    req(1, 4'd1, 1, 8'h10, 1, 8'h11, 16'h5A5A);
    tick();
    idle();
    tick();
    chk("ab_in_cap", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", {15'd0, busy}, 16'd0);
    chk("ab_cs", {15'd0, spram_cs}, 16'd0);
    chk("ab_wren", {15'd0, spram_wren}, 16'd0);
    chk("ab_addr", {2'b0, spram_addr}, 16'h0000);
    chk("ab_data", mem_data_out, 16'h0000);
    chk("ab_valid", {15'd0, rd_valid}, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_post_wren", {15'd0, spram_wren}, 16'd0);
      chk("ab_post_valid", {15'd0, rd_valid}, 16'd0);
    end

    // Out-of-range block select (NUM_BLOCKS=8)
    spram_rdata = 16'h0000;
    req(0, 4'd7, 0, 8'h00, 1, 8'h20, 16'hAAAA);
    tick();
    req(0, 4'd7, 1, 8'h20, 0, 8'h00, 16'h0000);
    tick();
    chk("oor_pre", mem_data_out, 16'hAAAA);
    req(0, 4'd15, 1, 8'h20, 0, 8'h00, 16'h0000);
    tick();
    chk("oor_rd_data", mem_data_out, 16'h0000);
    chk("oor_rd_valid", {15'd0, rd_valid}, 16'd1);
    req(0, 4'd15, 0, 8'h00, 1, 8'h20, 16'h5555);
    tick();
    req(0, 4'd7, 1, 8'h20, 0, 8'h00, 16'h0000);
    tick();
    chk("oor_wr_drop7", mem_data_out, 16'hAAAA);
    req(0, 4'd0, 1, 8'h20, 0, 8'h00, 16'h0000);
    tick();
    chk("oor_wr_drop0", (mem_data_out === 16'h5555) ? 16'd1 : 16'd0, 16'd0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory controller stage directly downstream of the compute clients (adder and similar).
- Accepts one client request per cycle: BRAM block select, read/write addresses, write data, enables, BRAM/SPRAM select.
- Serves BRAM from internal inferred EBR arrays. Serves SPRAM through the single-port SB_SPRAM256KA interface using a small sequencing FSM.
- Returns registered read data on mem_data_out, which feeds back to the client.

Parameters:
- MEM_SELECT_BITS, 4, width of mem_select.
- NUM_BLOCKS, 16, number of 256x16 BRAM blocks instantiated; must be <= 2**MEM_SELECT_BITS.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_select  in  MEM_SELECT_BITS  BRAM block index; SPRAM upper address bits.
- rd_addr  in  8  read address.
- wr_addr  in  8  write address.
- data_in  in  16  write data.
- rd_en  in  1  read request.
- wr_en  in  1  write request.
- bram_or_spram  in  1  0 = BRAM, 1 = SPRAM.
- mem_data_out  out  16  registered read data.
- rd_valid  out  1  one-cycle pulse; mem_data_out updated this cycle.
- busy  out  1  high while the SPRAM FSM is not IDLE; requests ignored.
- spram_addr  out  14  SPRAM address = {zero-extend(mem_select), addr}.
- spram_wdata  out  16  SPRAM write data.
- spram_cs  out  1  SPRAM chip select.
- spram_wren  out  1  SPRAM write enable.
- spram_rdata  in  16  SPRAM read data, valid the cycle after a read cycle.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; mem_data_out=0; rd_valid=0; busy=0; spram_cs=0; spram_wren=0; spram_addr=0; spram_wdata=0. BRAM contents are not reset.
- Request accepted on a rising edge only when busy=0. Accepted request with rd_en=wr_en=0 is a no-op.
- BRAM path (bram_or_spram=0, FSM stays IDLE):
  - Read latency 1: rd_en at edge N -> mem_data_out = bram[mem_select][rd_addr] and rd_valid=1 in cycle N+1.
  - Write commits at edge N.
  - Same-cycle read and write to the same address: read returns the old value (read-before-write).
  - mem_select >= NUM_BLOCKS: write dropped; read returns 0x0000 with rd_valid=1.
- mem_data_out holds its last value when no read completes.
- SPRAM FSM states: IDLE, SP_RD, SP_CAP, SP_WR.
  - Accept with rd_en=1 -> SP_RD. Accept with wr_en only -> SP_WR. Request fields latched on accept.
  - SP_RD: spram_cs=1, spram_wren=0, spram_addr={sel,rd_addr}. Next state SP_CAP.
  - SP_CAP: spram_cs=0. At end of cycle capture spram_rdata into mem_data_out; rd_valid=1 the following cycle. Next state SP_WR if a write is latched, else IDLE.
  - SP_WR: spram_cs=1, spram_wren=1, spram_addr={sel,wr_addr}, spram_wdata=latched data. Next state IDLE.
  - Read always precedes write, so read+write to the same address returns old data.
  - Latencies from accept edge: read-only, rd_valid 3 cycles later, busy for 2 cycles. Read+write, busy for 3 cycles. Write-only, busy for 1 cycle.
- busy is combinational from state (state != IDLE). While busy, all inputs are ignored; nothing is queued.
- Reset mid-SPRAM operation: FSM aborts immediately; a write not yet in SP_WR is never issued; no rd_valid is produced.
- Width rules: all data is 16-bit, no arithmetic. Address concatenation truncates mem_select to 6 bits if MEM_SELECT_BITS > 6.

Optional Feature:
- Macro: MEM_CTRL_WR_FORWARD_EN.
- Defined: BRAM read and write to the same block and address in the same cycle returns the new data_in on mem_data_out (write-first). SPRAM ordering is unchanged.
- Undefined: read-before-write as specified above.

Test Plan:
- Write bram[0][1]=0x0010, then read bram[0][1] -> one cycle later mem_data_out=0x0010, rd_valid=1 for exactly 1 cycle.
- BRAM same-cycle read+write bram[3][7] (old 0x1111, new 0x2222) -> mem_data_out=0x1111. With MEM_CTRL_WR_FORWARD_EN defined -> 0x2222. A subsequent read returns 0x2222 in both builds.
- Adder-style loop: bram[0][1]=0x0003; rd_addr=1, wr_addr=2, data_in=mem_data_out+5 held for 3 cycles -> bram[0][2]=0x0008.
- SPRAM read+write, sel=2, rd=0x05, wr=0x06, spram_rdata=0xBEEF -> spram_addr=0x0205 (read), then 0x0206 with wren=1; busy high for 3 cycles; mem_data_out=0xBEEF; request issued while busy is ignored.
- Assert rst_n=0 during SP_CAP of an SPRAM read+write -> spram_wren never asserted, rd_valid stays 0, all outputs at reset values immediately.
- Read with mem_select=15 and NUM_BLOCKS=8 -> mem_data_out=0x0000 with rd_valid=1; a write to the same select leaves all blocks unchanged.
